axis_threshold_calibrator: RTL

AXIS_THRESHOLD_CALIBRATOR -- requirements
Module: axis_threshold_calibrator

---
 rtl/axis_threshold_calibrator_if.sv | 21 ++
 rtl/axis_threshold_calibrator.sv | 136 +++++++++++++
 2 files changed

// File: rtl/axis_threshold_calibrator_if.sv
// AXI-Stream sample bus between a data source and the threshold calibrator.
// tready is driven by the calibrator; the source drives tvalid/tdata.
interface axis_threshold_calibrator_if #(
  parameter int W = 32
);
  logic         tvalid;
  logic [W-1:0] tdata;
  logic         tready;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/axis_threshold_calibrator.sv
// Min/max acquisition over a sample window; derives centered thresholds
// with span-proportional hysteresis for a downstream position tracker.
module axis_threshold_calibrator #(
  parameter  int S_AXIS_TDATA_WIDTH = 32,
  parameter  int WINDOW_LOG         = 10,
  parameter  int HYST_SHIFT         = 3,
  localparam int H                  = S_AXIS_TDATA_WIDTH / 2
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 continuous,
  input  logic [H-1:0]         min_span,
  axis_threshold_calibrator_if.slave S_AXIS,
  output logic signed [H-1:0]  lower_threshold,
  output logic signed [H-1:0]  upper_threshold,
  output logic                 thresholds_valid,
  output logic                 tracker_aresetn,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_COMP
  } state_t;

  localparam logic signed [H-1:0] C_POS = {1'b0, {(H-1){1'b1}}};
  localparam logic signed [H-1:0] C_NEG = {1'b1, {(H-1){1'b0}}};

  state_t                r_state;
  logic [WINDOW_LOG-1:0] r_cnt;
  logic signed [H-1:0]   r_min;
  logic signed [H-1:0]   r_max;
  logic [H-1:0]          r_lower;
  logic [H-1:0]          r_upper;
  logic                  r_valid;
  logic                  r_done;
  logic                  r_err;

  logic signed [H-1:0]   w_a;
  logic [H:0]            w_span;
  logic signed [H:0]     w_sum;
  logic signed [H:0]     w_center;
  logic [H:0]            w_hyst;
  logic [H:0]            w_lo;
  logic [H:0]            w_hi;
  logic                  w_ok;
  logic                  w_unused_b;

  assign w_a        = S_AXIS.tdata[H-1:0];
  assign w_unused_b = ^S_AXIS.tdata[S_AXIS_TDATA_WIDTH-1:H];

  // Window statistics, widened one bit so span and sum never overflow.
  assign w_span   = {r_max[H-1], r_max} - {r_min[H-1], r_min};
  assign w_sum    = {r_max[H-1], r_max} + {r_min[H-1], r_min};
  assign w_center = w_sum >>> 1;
  assign w_hyst   = w_span >> HYST_SHIFT;
  assign w_lo     = w_center - w_hyst;
  assign w_hi     = w_center + w_hyst;
  assign w_ok     = w_span >= {1'b0, min_span};

  assign S_AXIS.tready    = 1'b1;
  assign lower_threshold  = r_lower;
  assign upper_threshold  = r_upper;
  assign thresholds_valid = r_valid;
  assign tracker_aresetn  = r_valid;
  assign busy             = (r_state != S_IDLE);
  assign done             = r_done;
  assign error            = r_err;

  // Calibration FSM: acquire a window, evaluate it, apply or reject.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_min   <= C_POS;
      r_max   <= C_NEG;
      r_lower <= '0;
      r_upper <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ACQ;
            r_cnt   <= '0;
            r_min   <= C_POS;
            r_max   <= C_NEG;
          end
        end
        S_ACQ: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (S_AXIS.tvalid) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_a < r_min) r_min <= w_a;
            if (w_a > r_max) r_max <= w_a;
            if (r_cnt == '1) r_state <= S_COMP;
          end
        end
        S_COMP: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            if (w_ok) begin
              r_lower <= w_lo[H-1:0];
              r_upper <= w_hi[H-1:0];
              r_valid <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            if (continuous) begin
              r_state <= S_ACQ;
              r_cnt   <= '0;
              r_min   <= C_POS;
              r_max   <= C_NEG;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
